// File: rtl/voter_pkg.sv
// Shared types and helpers for the vote-based trade arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package voter_pkg;

    typedef enum logic {
        FLAT = 1'b0,
        LONG = 1'b1
    } pos_e;

    // Widest supported voter set; popcount is sized for it.
    localparam int MAX_ALGO = 8;

    // Width of the saturating statistics counters.
    localparam int STAT_W = 16;

    // Bits needed to hold a vote count from 0 to n_algo inclusive.
    function automatic int vote_w(input int n_algo);
        return $clog2(n_algo + 1);
    endfunction

    function automatic logic [3:0] popcount(input logic [MAX_ALGO-1:0] v);
        logic [3:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_ALGO; i++) begin
            cnt = cnt + {3'b000, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/vote_counter.sv
// Counts buy/sell votes; an algorithm raising both flags abstains.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module vote_counter
    import voter_pkg::*;
#(
    parameter int N_ALGO = 3,
    parameter int VOTE_W = vote_w(N_ALGO)
) (
    input  logic [N_ALGO-1:0] algo_buy,
    input  logic [N_ALGO-1:0] algo_sell,
    output logic [VOTE_W-1:0] buy_votes,
    output logic [VOTE_W-1:0] sell_votes
);

    logic [N_ALGO-1:0]   eff_buy;
    logic [N_ALGO-1:0]   eff_sell;
    logic [MAX_ALGO-1:0] buy_ext;
    logic [MAX_ALGO-1:0] sell_ext;
    logic [3:0]          buy_cnt;
    logic [3:0]          sell_cnt;

    // A voter asserting both directions contributes to neither count.
    assign eff_buy  = algo_buy & ~algo_sell;
    assign eff_sell = algo_sell & ~algo_buy;

    assign buy_ext  = MAX_ALGO'(eff_buy);
    assign sell_ext = MAX_ALGO'(eff_sell);

    assign buy_cnt  = popcount(buy_ext);
    assign sell_cnt = popcount(sell_ext);

    assign buy_votes  = VOTE_W'(buy_cnt);
    assign sell_votes = VOTE_W'(sell_cnt);

endmodule

// File: rtl/vote_trade_arbiter.sv
// Per-stock FLAT/LONG arbiter driven by thresholded algorithm votes with sample-based cooldown.
// Latency: 1 cycle from accepted sample to registered out_valid/signals/position.
// Backpressure: none; accepts one sample per cycle, out-of-range stock ids are dropped.
// Optional: define VOTER_STATS_EN for saturating trade_count / suppressed_count outputs.
module vote_trade_arbiter
    import voter_pkg::*;
#(
    parameter int N_ALGO   = 3,
    parameter int N_STOCK  = 4,
    parameter int SID_W    = 2,
    parameter int THRESH   = 2,
    parameter int COOLDOWN = 4,
    parameter int VOTE_W   = vote_w(N_ALGO)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [SID_W-1:0]   in_stock_id,
    input  logic [N_ALGO-1:0]  algo_buy,
    input  logic [N_ALGO-1:0]  algo_sell,
    output logic               out_valid,
    output logic [SID_W-1:0]   out_stock_id,
    output logic               buy_signal,
    output logic               sell_signal,
    output logic [VOTE_W-1:0]  buy_votes,
    output logic [VOTE_W-1:0]  sell_votes,
    output logic [N_STOCK-1:0] position
`ifdef VOTER_STATS_EN
    ,
    output logic [STAT_W-1:0]  trade_count,
    output logic [STAT_W-1:0]  suppressed_count
`endif
);

    // Cooldown counter needs at least one bit even when cooldown is disabled.
    localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN);

    // Reject configurations the counters and compares cannot represent.
    if (N_ALGO < 1 || N_ALGO > MAX_ALGO) begin : g_bad_n_algo
        $error("vote_trade_arbiter: N_ALGO must be 1..8");
    end
    if (THRESH < 1 || THRESH > N_ALGO) begin : g_bad_thresh
        $error("vote_trade_arbiter: THRESH must be 1..N_ALGO");
    end
    if (N_STOCK < 1 || SID_W < $clog2(N_STOCK)) begin : g_bad_sid_w
        $error("vote_trade_arbiter: SID_W too narrow for N_STOCK");
    end
    if (COOLDOWN < 0) begin : g_bad_cooldown
        $error("vote_trade_arbiter: COOLDOWN must be >= 0");
    end

    logic [VOTE_W-1:0] buy_cnt;
    logic [VOTE_W-1:0] sell_cnt;

    vote_counter #(
        .N_ALGO (N_ALGO),
        .VOTE_W (VOTE_W)
    ) u_vote_counter (
        .algo_buy   (algo_buy),
        .algo_sell  (algo_sell),
        .buy_votes  (buy_cnt),
        .sell_votes (sell_cnt)
    );

    pos_e          pos_q  [N_STOCK];
    pos_e          pos_d  [N_STOCK];
    logic [CW-1:0] cool_q [N_STOCK];
    logic [CW-1:0] cool_d [N_STOCK];

    logic [N_STOCK-1:0] hit;
    pos_e               cur_pos;
    logic [CW-1:0]      cur_cool;
    logic               accept;
    logic               buy_req;
    logic               sell_req;
    logic               do_buy;
    logic               do_sell;

    // Decode the addressed stock and fetch its current state; no hit for out-of-range ids.
    always_comb begin
        hit      = '0;
        cur_pos  = FLAT;
        cur_cool = '0;
        for (int i = 0; i < N_STOCK; i++) begin
            if (in_valid && (int'(in_stock_id) == i)) begin
                hit[i]   = 1'b1;
                cur_pos  = pos_q[i];
                cur_cool = cool_q[i];
            end
        end
    end

    assign accept   = |hit;
    assign buy_req  = (int'(buy_cnt) >= THRESH) && (buy_cnt > sell_cnt);
    assign sell_req = (int'(sell_cnt) >= THRESH) && (sell_cnt > buy_cnt);
    assign do_buy   = accept && buy_req && (cur_pos == FLAT) && (cur_cool == '0);
    assign do_sell  = accept && sell_req && (cur_pos == LONG) && (cur_cool == '0);

    // Next position/cooldown: a trade reloads cooldown, any other accepted sample counts it down.
    always_comb begin
        for (int i = 0; i < N_STOCK; i++) begin
            pos_d[i]  = pos_q[i];
            cool_d[i] = cool_q[i];
            if (hit[i]) begin
                if (do_buy) begin
                    pos_d[i]  = LONG;
                    cool_d[i] = COOL_LOAD;
                end else if (do_sell) begin
                    pos_d[i]  = FLAT;
                    cool_d[i] = COOL_LOAD;
                end else if (cool_q[i] != '0) begin
                    cool_d[i] = cool_q[i] - CW'(1);
                end
            end
        end
    end

    // Per-stock state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_STOCK; i++) begin
                pos_q[i]  <= FLAT;
                cool_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_STOCK; i++) begin
                pos_q[i]  <= pos_d[i];
                cool_q[i] <= cool_d[i];
            end
        end
    end

    // Position bitmap comes straight from the state register, so it moves with out_valid.
    always_comb begin
        position = '0;
        for (int i = 0; i < N_STOCK; i++) begin
            position[i] = (pos_q[i] == LONG);
        end
    end

    // Registered decision outputs; vote counts and stock id hold while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_stock_id <= '0;
            buy_signal   <= 1'b0;
            sell_signal  <= 1'b0;
            buy_votes    <= '0;
            sell_votes   <= '0;
        end else begin
            out_valid   <= accept;
            buy_signal  <= do_buy;
            sell_signal <= do_sell;
            if (accept) begin
                out_stock_id <= in_stock_id;
                buy_votes    <= buy_cnt;
                sell_votes   <= sell_cnt;
            end
        end
    end

`ifdef VOTER_STATS_EN
    logic suppressed;

    // A request that neither trades is blocked by cooldown or by the current position.
    assign suppressed = accept && (buy_req || sell_req) && !(do_buy || do_sell);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trade_count      <= '0;
            suppressed_count <= '0;
        end else begin
            if ((do_buy || do_sell) && (trade_count != '1)) begin
                trade_count <= trade_count + STAT_W'(1);
            end
            if (suppressed && (suppressed_count != '1)) begin
                suppressed_count <= suppressed_count + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_vote_trade_arbiter.sv
// Directed test of vote_trade_arbiter: a 4-stock build plus a 3-stock build sharing stimulus.
// Latency: outputs checked 1 ns after the edge that registers each sample.
// Backpressure: n/a; the bench drives at most one sample per cycle.
module tb_vote_trade_arbiter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_stock_id;
    logic [2:0] algo_buy;
    logic [2:0] algo_sell;

    logic       out_valid;
    logic [1:0] out_stock_id;
    logic       buy_signal;
    logic       sell_signal;
    logic [1:0] buy_votes;
    logic [1:0] sell_votes;
    logic [3:0] position;

    logic       out_valid3;
    logic [1:0] out_stock_id3;
    logic       buy_signal3;
    logic       sell_signal3;
    logic [1:0] buy_votes3;
    logic [1:0] sell_votes3;
    logic [2:0] position3;

`ifdef VOTER_STATS_EN
    logic [15:0] trade_count;
    logic [15:0] suppressed_count;
    logic [15:0] trade_count3;
    logic [15:0] suppressed_count3;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    vote_trade_arbiter #(
        .N_ALGO(3), .N_STOCK(4), .SID_W(2), .THRESH(2), .COOLDOWN(4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_stock_id  (in_stock_id),
        .algo_buy     (algo_buy),
        .algo_sell    (algo_sell),
        .out_valid    (out_valid),
        .out_stock_id (out_stock_id),
        .buy_signal   (buy_signal),
        .sell_signal  (sell_signal),
        .buy_votes    (buy_votes),
        .sell_votes   (sell_votes),
        .position     (position)
`ifdef VOTER_STATS_EN
        ,
        .trade_count      (trade_count),
        .suppressed_count (suppressed_count)
`endif
    );

    vote_trade_arbiter #(
        .N_ALGO(3), .N_STOCK(3), .SID_W(2), .THRESH(2), .COOLDOWN(4)
    ) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_stock_id  (in_stock_id),
        .algo_buy     (algo_buy),
        .algo_sell    (algo_sell),
        .out_valid    (out_valid3),
        .out_stock_id (out_stock_id3),
        .buy_signal   (buy_signal3),
        .sell_signal  (sell_signal3),
        .buy_votes    (buy_votes3),
        .sell_votes   (sell_votes3),
        .position     (position3)
`ifdef VOTER_STATS_EN
        ,
        .trade_count      (trade_count3),
        .suppressed_count (suppressed_count3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Compare every main-instance output against one expected vector.
    task automatic check_out(input string tag, input logic ov, input logic [1:0] sid,
                             input logic bs, input logic ss, input logic [1:0] bv,
                             input logic [1:0] sv, input logic [3:0] pos);
        check({tag, ".out_valid"},    32'(out_valid),    32'(ov));
        check({tag, ".out_stock_id"}, 32'(out_stock_id), 32'(sid));
        check({tag, ".buy_signal"},   32'(buy_signal),   32'(bs));
        check({tag, ".sell_signal"},  32'(sell_signal),  32'(ss));
        check({tag, ".buy_votes"},    32'(buy_votes),    32'(bv));
        check({tag, ".sell_votes"},   32'(sell_votes),   32'(sv));
        check({tag, ".position"},     32'(position),     32'(pos));
    endtask

    // Drive one sample (or idle) at the falling edge; return just after the registering edge.
    task automatic step(input logic v, input logic [1:0] id, input logic [2:0] b, input logic [2:0] s);
        @(negedge clk);
        in_valid    = v;
        in_stock_id = id;
        algo_buy    = b;
        algo_sell   = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_stock_id = 2'd0;
        algo_buy    = 3'b000;
        algo_sell   = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
        check("reset.position3", 32'(position3), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Two-of-three buy on stock 1 enters long.
        step(1'b1, 2'd1, 3'b011, 3'b000);
        check_out("t1_buy", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd0, 4'b0010);

        // Algo0 abstains: 1 buy vs 1 sell, no request.
        step(1'b1, 2'd1, 3'b011, 3'b101);
        check_out("t2_abstain", 1'b1, 2'd1, 1'b0, 1'b0, 2'd1, 2'd1, 4'b0010);

        // Idle: no pulse, votes hold.
        step(1'b0, 2'd0, 3'b000, 3'b000);
        check_out("idle_hold", 1'b0, 2'd1, 1'b0, 1'b0, 2'd1, 2'd1, 4'b0010);

        // Stock 0 buy, then back-to-back sells held off by cooldown.
        step(1'b1, 2'd0, 3'b111, 3'b000);
        check_out("t3_buy0", 1'b1, 2'd0, 1'b1, 1'b0, 2'd3, 2'd0, 4'b0011);
        step(1'b1, 2'd0, 3'b000, 3'b111);
        check_out("t3_cool1", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 4'b0011);
        step(1'b1, 2'd0, 3'b000, 3'b111);
        check_out("t3_cool2", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 4'b0011);
        // Other stock trades freely and does not consume stock 0 cooldown.
        step(1'b1, 2'd2, 3'b110, 3'b000);
        check_out("t3_buy2", 1'b1, 2'd2, 1'b1, 1'b0, 2'd2, 2'd0, 4'b0111);
        step(1'b1, 2'd0, 3'b000, 3'b111);
        check_out("t3_cool3", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 4'b0111);
        step(1'b1, 2'd0, 3'b000, 3'b111);
        check_out("t3_cool4", 1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 2'd3, 4'b0111);
        step(1'b1, 2'd0, 3'b000, 3'b111);
        check_out("t3_sell0", 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, 2'd3, 4'b0110);

        // Stock 3 long, then four quiet samples drain its cooldown.
        step(1'b1, 2'd3, 3'b111, 3'b000);
        check_out("t4_buy3", 1'b1, 2'd3, 1'b1, 1'b0, 2'd3, 2'd0, 4'b1110);
        check("t5_drop.out_valid3", 32'(out_valid3), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd3, 3'b000, 3'b000);
        end
        check_out("t4_drain", 1'b1, 2'd3, 1'b0, 1'b0, 2'd0, 2'd0, 4'b1110);

        // Buy while already long is ignored; the 3-stock build drops id 3 entirely.
        step(1'b1, 2'd3, 3'b111, 3'b000);
        check_out("t4_long_buy", 1'b1, 2'd3, 1'b0, 1'b0, 2'd3, 2'd0, 4'b1110);
        check("t5_drop2.out_valid3", 32'(out_valid3), 32'd0);
        check("t5_drop2.position3",  32'(position3),  32'b110);
        check("t5_drop2.buy_votes3", 32'(buy_votes3), 32'd0);

        // Next in-range sample is processed by both builds (stock 2 still cooling).
        step(1'b1, 2'd2, 3'b000, 3'b111);
        check_out("t5_next", 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd3, 4'b1110);
        check("t5_next.out_valid3",   32'(out_valid3),   32'd1);
        check("t5_next.sell_votes3",  32'(sell_votes3),  32'd3);
        check("t5_next.sell_signal3", 32'(sell_signal3), 32'd0);
        check("t5_next.stock_id3",    32'(out_stock_id3), 32'd2);
`ifdef VOTER_STATS_EN
        check("stats.trade_count",      32'(trade_count),      32'd5);
        check("stats.suppressed_count", 32'(suppressed_count), 32'd6);
`endif

        // Asynchronous reset in mid-cycle clears state without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        check("t6_arst.position",  32'(position),  32'd0);
        check("t6_arst.out_valid", 32'(out_valid), 32'd0);
        check("t6_arst.position3", 32'(position3), 32'd0);
`ifdef VOTER_STATS_EN
        check("t6_arst.trade_count", 32'(trade_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Stock 1 was long before reset; a clean state lets it buy again at once.
        step(1'b1, 2'd1, 3'b110, 3'b000);
        check_out("t6_rebuy", 1'b1, 2'd1, 1'b1, 1'b0, 2'd2, 2'd0, 4'b0010);
        check("t6_rebuy.buy_signal3", 32'(buy_signal3), 32'd1);
        check("t6_rebuy.position3",   32'(position3),   32'b010);

        // One vote is below threshold.
        step(1'b1, 2'd3, 3'b100, 3'b000);
        check_out("below_thresh", 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 2'd0, 4'b0010);

        step(1'b0, 2'd0, 3'b000, 3'b000);
        check_out("final_idle", 1'b0, 2'd3, 1'b0, 1'b0, 2'd1, 2'd0, 4'b0010);
`ifdef VOTER_STATS_EN
        check("final.trade_count",      32'(trade_count),      32'd1);
        check("final.suppressed_count", 32'(suppressed_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
